// File: rtl/packed_array_pkg.sv
// Shared types for packed-array producers and consumers.
// Default geometry: three 4-bit elements per word.
package packed_array_pkg;

   localparam int NUM_ELEM_DEF = 3;
   localparam int ELEM_W_DEF   = 4;
   localparam int CNT_W_DEF    = $clog2(NUM_ELEM_DEF + 1);

   typedef logic [NUM_ELEM_DEF-1:0][ELEM_W_DEF-1:0] packed_word_t;
   typedef logic [CNT_W_DEF-1:0]                    elem_cnt_t;

endpackage

// File: rtl/packed_out_reg.sv
// Output word register: holds under backpressure, accepts a new
// word in the same cycle the old one is popped.
module packed_out_reg
   import packed_array_pkg::*;
#(
   parameter int NUM_ELEM = NUM_ELEM_DEF,
   parameter int ELEM_W   = ELEM_W_DEF,
   parameter int CNT_W    = $clog2(NUM_ELEM + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load,
   input  logic [NUM_ELEM-1:0][ELEM_W-1:0]  load_data,
   input  logic [CNT_W-1:0]                 load_count,
   input  logic                             out_ready,
   output logic                             out_valid,
   output logic [NUM_ELEM-1:0][ELEM_W-1:0]  out_data,
   output logic [CNT_W-1:0]                 out_count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_count <= load_count;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/packed_nibble_assembler.sv
// Assembles a stream of elements into packed words, element 0 first.
// PACKED_ASM_FLUSH_EN adds a flush input that emits a partial word.
module packed_nibble_assembler
   import packed_array_pkg::*;
#(
   parameter int NUM_ELEM = NUM_ELEM_DEF,
   parameter int ELEM_W   = ELEM_W_DEF
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [ELEM_W-1:0]                       in_data,
`ifdef PACKED_ASM_FLUSH_EN
   input  logic                                    flush,
`endif
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [NUM_ELEM-1:0][ELEM_W-1:0]         out_data,
   output logic [$clog2(NUM_ELEM+1)-1:0]           out_count
);

   localparam int IW = $clog2(NUM_ELEM);
   localparam int CW = $clog2(NUM_ELEM + 1);

   typedef logic [NUM_ELEM-1:0][ELEM_W-1:0] word_t;

   logic [IW-1:0] idx;
   word_t         acc;
   word_t         full_word;
   word_t         load_data;
   logic [CW-1:0] load_count;
   logic          last;
   logic          in_fire;
   logic          load;
   logic          emit;
   logic          blocked;

   assign last    = (idx == IW'(NUM_ELEM - 1));
   assign in_fire = in_valid && in_ready;

   always_comb begin
      full_word = acc;
      full_word[NUM_ELEM-1] = in_data;
   end

`ifdef PACKED_ASM_FLUSH_EN
   logic          pend;
   logic [IW-1:0] idx_after;

   assign emit    = pend && (!out_valid || out_ready);
   assign blocked = pend;

   always_comb begin
      idx_after = idx;
      if (in_fire)
         idx_after = last ? '0 : idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         pend <= 1'b0;
      else if (emit)
         pend <= 1'b0;
      else if (flush && idx_after != '0)
         pend <= 1'b1;
   end
`else
   assign emit    = 1'b0;
   assign blocked = 1'b0;
`endif

   // Only the closing element needs the output slot, so only it stalls.
   assign in_ready = !(last && out_valid && !out_ready) && !blocked;

   assign load       = (in_fire && last) || emit;
   assign load_data  = emit ? acc : full_word;
   assign load_count = emit ? CW'(idx) : CW'(NUM_ELEM);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         acc <= '0;
      end else if (emit || (in_fire && last)) begin
         idx <= '0;
         acc <= '0;
      end else if (in_fire) begin
         idx      <= idx + 1'b1;
         acc[idx] <= in_data;
      end
   end

   packed_out_reg #(
      .NUM_ELEM (NUM_ELEM),
      .ELEM_W   (ELEM_W),
      .CNT_W    (CW)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_data  (load_data),
      .load_count (load_count),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_count  (out_count)
   );

endmodule

// File: tb/tb_packed_nibble_assembler.sv
// Directed bench for packed_nibble_assembler (3 x 4-bit default).
module tb_packed_nibble_assembler;
   import packed_array_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_data;
   logic         out_valid;
   logic         out_ready;
   packed_word_t out_data;
   elem_cnt_t    out_count;
`ifdef PACKED_ASM_FLUSH_EN
   logic         flush;
`endif

   int n_vec = 0;
   int n_bad = 0;

   logic [11:0] qd[$];
   logic [1:0]  qc[$];
   bit          stall_seen;

   always #5 clk = ~clk;

   packed_nibble_assembler dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef PACKED_ASM_FLUSH_EN
      .flush     (flush),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
   );

   // Record every output transfer; inputs only change just after posedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         qd.push_back(out_data);
         qc.push_back(out_count);
      end
      if (in_valid && !in_ready)
         stall_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d);
      int waited;
      waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("send_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         #1;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic clear_q();
      qd.delete();
      qc.delete();
   endtask

   task automatic chk_q(input string tag, input int i,
                        input logic [11:0] d, input logic [1:0] c);
      if (i >= qd.size()) begin
         chk({tag, "_missing"}, 32'(qd.size()), 32'(i + 1));
      end else begin
         chk({tag, "_data"}, 32'(qd[i]), 32'(d));
         chk({tag, "_cnt"}, 32'(qc[i]), 32'(c));
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
`ifdef PACKED_ASM_FLUSH_EN
      flush     = 1'b0;
`endif
      idle(3);
      rst = 1'b0;

      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      @(posedge clk);
      #1;

      // single word, one cycle latency
      clear_q();
      send(4'h1);
      send(4'h2);
      send(4'h3);
      @(negedge clk);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'h321);
      chk("single_cnt", 32'(out_count), 32'd3);
      idle(3);
      chk("single_nwords", 32'(qd.size()), 32'd1);

      // streaming, no stalls
      clear_q();
      stall_seen = 1'b0;
      for (int i = 1; i <= 9; i++)
         send(4'(i));
      idle(3);
      chk("stream_nwords", 32'(qd.size()), 32'd3);
      chk_q("stream0", 0, 12'h321, 2'd3);
      chk_q("stream1", 1, 12'h654, 2'd3);
      chk_q("stream2", 2, 12'h987, 2'd3);
      chk("stream_stall", 32'(stall_seen), 32'd0);

      // backpressure
      clear_q();
      out_ready = 1'b0;
      send(4'h1);
      send(4'h2);
      send(4'h3);
      send(4'h4);
      send(4'h5);
      in_valid = 1'b1;
      in_data  = 4'h6;
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'h321);
      idle(2);
      @(negedge clk);
      chk("bp_stable_valid", 32'(out_valid), 32'd1);
      chk("bp_stable_data", 32'(out_data), 32'h321);
      chk("bp_stable_cnt", 32'(out_count), 32'd3);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_valid", 32'(out_valid), 32'd1);
      chk("bp_next_data", 32'(out_data), 32'h654);
      idle(2);
      chk("bp_nwords", 32'(qd.size()), 32'd2);
      chk_q("bp0", 0, 12'h321, 2'd3);
      chk_q("bp1", 1, 12'h654, 2'd3);

      // reset mid-fill drops the partial word
      clear_q();
      send(4'h7);
      send(4'h8);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      send(4'h1);
      send(4'h2);
      send(4'h3);
      idle(3);
      chk("rstmid_nwords", 32'(qd.size()), 32'd1);
      chk_q("rstmid", 0, 12'h321, 2'd3);

`ifdef PACKED_ASM_FLUSH_EN
      // flush of a partial word
      clear_q();
      send(4'hA);
      send(4'hB);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      idle(3);
      send(4'h1);
      send(4'h2);
      send(4'h3);
      idle(3);
      chk("flush_nwords", 32'(qd.size()), 32'd2);
      chk_q("flush0", 0, 12'h0BA, 2'd2);
      chk_q("flush1", 1, 12'h321, 2'd3);

      // flush while the output slot is occupied
      clear_q();
      out_ready = 1'b0;
      send(4'h1);
      send(4'h2);
      send(4'h3);
      send(4'hC);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      @(negedge clk);
      chk("fblk_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      idle(3);
      chk("fblk_nwords", 32'(qd.size()), 32'd2);
      chk_q("fblk0", 0, 12'h321, 2'd3);
      chk_q("fblk1", 1, 12'h00C, 2'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/packed_nibble_assembler.md
# packed_nibble_assembler

Collects a stream of narrow elements, one per handshake, and assembles them into a multi-dimensional packed word of `NUM_ELEM` elements of `ELEM_W` bits. Element 0 is the first received. It sits directly upstream of the packed-array consumers and display helpers, which take `logic [NUM_ELEM-1:0][ELEM_W-1:0]` words. Both the input and the output use valid/ready handshakes, and the block sustains one element per cycle.

## Interface
Parameters:
- `NUM_ELEM`, default 3: number of elements per packed word (≥2).
- `ELEM_W`, default 4: bits per element.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  block can accept an element this cycle.
- `in_data`  in  `ELEM_W`  input element.
- `out_valid`  out  1  assembled word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  `packed_word_t` (`[NUM_ELEM-1:0][ELEM_W-1:0]`)  assembled word.
- `out_count`  out  `$clog2(NUM_ELEM+1)`  number of meaningful elements in `out_data`.
- `flush`  in  1  present only with `PACKED_ASM_FLUSH_EN`; emits a partial word.

## Operation
- **Transfers.** An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **State.**
  - Fill index `idx`, range 0..`NUM_ELEM-1`.
  - Accumulator `acc` of type `packed_word_t`.
  - Output register holding `out_data`, `out_count` and `out_valid`.
- **Non-last element** (`idx < NUM_ELEM-1`): the accepted element is written to `acc[idx]` and `idx` increments.
- **Last element** (`idx == NUM_ELEM-1`):
  - The output register is loaded with `acc`, with element `[NUM_ELEM-1]` taken from `in_data`.
  - `out_count` is loaded with `NUM_ELEM` and `out_valid` is set.
  - `idx` returns to 0 and `acc` clears.
- **`in_ready` rule.** `in_ready = !(idx == NUM_ELEM-1 && out_valid && !out_ready)`, with one further term under flush (see Configuration). Only the last element is ever stalled by backpressure.
- **Simultaneous load and pop.** When an output transfer and a new word load happen in the same cycle, the new word replaces the old one and `out_valid` stays 1.
- **Output pop with no new load.** `out_valid` clears; `out_data` keeps its old value (don't-care).
- **Stability.** While `out_valid && !out_ready`, `out_data` and `out_count` hold stable.
- **Input hold.** `in_data` must be held while `in_valid && !in_ready`. `in_valid` must not drop without a transfer.
- **Reset values.**
  - `in_ready` = 1, `out_valid` = 0.
  - `out_data` = 0, `out_count` = 0.
  - `idx` = 0, `acc` = 0, flush pending = 0.
- **Reset mid-fill.** A partially filled word is discarded without being emitted.

## Timing
- **Latency.** `out_valid` rises on the cycle after the last element's input transfer.
- **Throughput.** With `out_ready` held at 1, one element is accepted every cycle and one word is emitted every `NUM_ELEM` cycles.
- **Combinational paths.** `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_*` to `out_*`.

## Configuration
Macro: `PACKED_ASM_FLUSH_EN`.

Defined:
- The `flush` port exists and is sampled each cycle. `flush` set with `idx > 0` (after including any element accepted that same cycle) sets a pending flag.
- While the flag is pending, `in_ready` = 0.
- On the first cycle the output slot is free (`!out_valid || out_ready`), the block emits `acc` with unfilled elements set to 0 and `out_count = idx`. It then clears `idx`, `acc` and the pending flag.
- `flush` with `idx == 0`, or coinciding with completion of a full word, is ignored. In that case the full word is emitted normally with `out_count = NUM_ELEM`.

Undefined:
- No `flush` port and no pending logic.
- `out_count` is `NUM_ELEM` whenever `out_valid` is 1.

## Structure
- **Shared package `packed_array_pkg`** holds:
  - Constants `NUM_ELEM_DEF` = 3 and `ELEM_W_DEF` = 4.
  - `typedef logic [NUM_ELEM_DEF-1:0][ELEM_W_DEF-1:0] packed_word_t`.
  - Count type `elem_cnt_t`.
- **Sub-module.** One natural sub-module, `packed_out_reg`: the output register with valid/ready hold and load-while-pop. The fill counter and accumulator live in the top level.

## Test plan
- **Single word.** Send `0x1`, `0x2`, `0x3` with `out_ready` = 1 → one cycle after the third transfer, `out_valid` = 1, `out_data` = 12'h321 (`[0]`=1, `[1]`=2, `[2]`=3), `out_count` = 3.
- **Streaming.** Send 9 elements on consecutive cycles with `out_ready` = 1 → 3 words (12'h321, 12'h654, 12'h987), `in_ready` never drops.
- **Backpressure.** Hold `out_ready` = 0 and send 6 elements → word 12'h321 is held stable, `0x4` and `0x5` are accepted, and `in_ready` = 0 at `0x6`. Raise `out_ready` → `0x6` is accepted in the same cycle and the next word is 12'h654.
- **Reset mid-fill.** Send `0x7`, `0x8`, then pulse `rst` for one cycle, then send `0x1`, `0x2`, `0x3` → the only word emitted is 12'h321.
- **Flush (`PACKED_ASM_FLUSH_EN`).** Send `0xA`, `0xB`, then `flush` → `out_data` = 12'h0BA, `out_count` = 2. A subsequent `0x1`, `0x2`, `0x3` → 12'h321, `out_count` = 3.
- **Flush while output blocked.** With a full word held and `out_ready` = 0, send `0xC` then `flush` → `in_ready` = 0 while pending. After a pop, the next word is 12'h00C with `out_count` = 1.
